// File: rtl/seq_controller_pkg.sv
// Shared encodings for the pattern sequencer: FSM state codes and ping-pong direction.
package seq_controller_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/seq_controller_prescaler_en.sv
// Free-running NP-bit step prescaler with count enable and synchronous clear;
// tick_o flags the enabled cycle in which the counter wraps from all-ones to zero.
module prescaler_en #(
  parameter int NP = 22
) (
  input  logic clk,
  input  logic rstn,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [NP-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + NP'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == '1);

endmodule

// File: rtl/seq_controller.sv
// Programmable 4-bit pattern sequencer with start/stop/pause/loop control.
// Optional feature: define SEQ_PINGPONG_EN to bounce between index 0 and len in loop mode.
module seq_controller #(
  parameter int NP    = 22,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          loop,
  input  logic [AW-1:0] len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  output logic [3:0]    data,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          done
);

  import seq_controller_pkg::*;

  state_t        state_q, state_d;
  logic [3:0]    data_q, data_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] len_q, len_d;
  logic          done_q, done_d;
  logic [3:0]    table_q [DEPTH];

  logic          seqActive;
  logic          presTick;
  logic          loadEn;
  logic [AW-1:0] idxInc;

`ifdef SEQ_PINGPONG_EN
  logic          dir_q, dir_d;
  logic [AW-1:0] idxDec;
  assign idxDec = idx_q - AW'(1);
`endif

  assign idxInc = idx_q + AW'(1);

  // The prescaler only advances on cycles where the sequence is really running,
  // so a pause shifts the whole schedule by exactly the cycles pause was high.
  assign seqActive = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !pause && !stop && !start;

  prescaler_en #(.NP(NP)) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (seqActive),
    .clr_i  (start || stop),
    .tick_o (presTick)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    loadEn  = 1'b0;
`ifdef SEQ_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (stop) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      data_d  = '0;
`ifdef SEQ_PINGPONG_EN
      dir_d   = DIR_UP;
`endif
    end else if (start) begin
      state_d = ST_RUN;
      idx_d   = '0;
      len_d   = len;
      loadEn  = 1'b1;
`ifdef SEQ_PINGPONG_EN
      dir_d   = DIR_UP;
`endif
    end else if ((state_q == ST_RUN) || (state_q == ST_PAUSE)) begin
      if (pause) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = ST_RUN;
        if (presTick) begin
`ifdef SEQ_PINGPONG_EN
          if (dir_q == DIR_UP) begin
            if (idx_q < len_q) begin
              idx_d  = idxInc;
              loadEn = 1'b1;
            end else if (!loop) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else if (len_q == '0) begin
              idx_d  = '0;
              loadEn = 1'b1;
            end else begin
              dir_d  = DIR_DOWN;
              idx_d  = idxDec;
              loadEn = 1'b1;
            end
          end else begin
            if (idx_q != '0) begin
              idx_d  = idxDec;
              loadEn = 1'b1;
            end else if (!loop) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              dir_d  = DIR_UP;
              idx_d  = idxInc;
              loadEn = 1'b1;
            end
          end
`else
          if (idx_q < len_q) begin
            idx_d  = idxInc;
            loadEn = 1'b1;
          end else if (loop) begin
            idx_d  = '0;
            loadEn = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end
    end
    // Reads the pre-write table contents, so a same-cycle write is seen only on the next load.
    if (loadEn) begin
      data_d = table_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

`ifdef SEQ_PINGPONG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign data = data_q;
  assign idx  = idx_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done = done_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed self-checking bench for seq_controller with NP=1 (one step every two clocks).
// Honours SEQ_PINGPONG_EN for the loop-mode expectations.
module tb_seq_controller;

  localparam int AW = 3;

`ifdef SEQ_PINGPONG_EN
  localparam int REVISIT = 12;
`else
  localparam int REVISIT = 8;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          stop;
  logic          pause;
  logic          loop;
  logic [AW-1:0] len;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic [3:0]    data;
  logic [AW-1:0] idx;
  logic          busy;
  logic          done;

  int assertCount = 0;
  int failCount   = 0;

  logic [3:0] singleData [9];
  logic [2:0] singleIdx  [9];
  logic [3:0] loopData   [8];
  logic [2:0] loopIdx    [8];

  seq_controller #(.NP(1), .DEPTH(8), .AW(AW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .loop    (loop),
    .len     (len),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .data    (data),
    .idx     (idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] expData, input logic [2:0] expIdx,
                            input logic expBusy, input logic expDone);
    checkOutput({tag, "/data"}, 32'(data), 32'(expData));
    checkOutput({tag, "/idx"},  32'(idx),  32'(expIdx));
    checkOutput({tag, "/busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, "/done"}, 32'(done), 32'(expDone));
  endtask

  // Drives the control inputs for one clock; start/stop are released afterwards as pulses.
  task automatic applyStimulus(input logic s, input logic p, input logic ps, input logic lp, input logic [2:0] l);
    start = s;
    stop  = p;
    pause = ps;
    loop  = lp;
    len   = l;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic writeTable(input logic [2:0] addr, input logic [3:0] val);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = val;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    singleData = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8};
    singleIdx  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};
`ifdef SEQ_PINGPONG_EN
    loopData = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    loopIdx  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
`else
    loopData = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    loopIdx  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
`endif

    rstn    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    pause   = 1'b0;
    loop    = 1'b0;
    len     = 3'd0;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 4'h0;
    #12;
    checkState("reset", 4'h0, 3'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    step();

    writeTable(3'd0, 4'h1);
    writeTable(3'd1, 4'h2);
    writeTable(3'd2, 4'h4);
    writeTable(3'd3, 4'h8);
    writeTable(3'd4, 4'h9);

    // Single pass: each pattern lasts two clocks, done pulses once at the end.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    for (int k = 0; k <= 8; k++) begin
      checkState($sformatf("single s%0d", k), singleData[k], singleIdx[k], (k < 8), (k == 8));
      step();
    end
    checkState("single hold", 4'h8, 3'd3, 1'b0, 1'b0);
    step();
    checkState("done hold", 4'h8, 3'd3, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    checkState("start+stop", 4'h0, 3'd0, 1'b0, 1'b0);

    // Loop mode over two full passes (wrap or bounce).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
    for (int k = 0; k < 8; k++) begin
      checkState($sformatf("loop s%0d", 2 * k), loopData[k], loopIdx[k], 1'b1, 1'b0);
      step();
      step();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
    checkState("stop in run", 4'h0, 3'd0, 1'b0, 1'b0);

    // Pause for six clocks while showing 2; the schedule shifts by exactly six clocks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    step();
    step();
    checkState("pause pre", 4'h2, 3'd1, 1'b1, 1'b0);
    pause = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checkState($sformatf("pause hold %0d", k), 4'h2, 3'd1, 1'b1, 1'b0);
    end
    pause = 1'b0;
    step();
    checkState("resume s9", 4'h2, 3'd1, 1'b1, 1'b0);
    step();
    checkState("resume s10", 4'h4, 3'd2, 1'b1, 1'b0);
    step();
    checkState("resume s11", 4'h4, 3'd2, 1'b1, 1'b0);
    step();
    checkState("resume s12", 4'h8, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd3);

    // Overwrite table[0] in the same cycle as the start load, then see it on revisit.
    start   = 1'b1;
    loop    = 1'b1;
    len     = 3'd3;
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 4'hF;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    checkState("collide s0", 4'h1, 3'd0, 1'b1, 1'b0);
    step();
    checkState("written s1", 4'h1, 3'd0, 1'b1, 1'b0);
    for (int k = 2; k < REVISIT; k++) begin
      step();
    end
`ifdef SEQ_PINGPONG_EN
    checkState("pre revisit", 4'h2, 3'd1, 1'b1, 1'b0);
`else
    checkState("pre revisit", 4'h8, 3'd3, 1'b1, 1'b0);
`endif
    step();
    checkState("revisit", 4'hF, 3'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-run, released before the next clock edge.
    rstn = 1'b0;
    #1;
    checkState("async rst", 4'h0, 3'd0, 1'b0, 1'b0);
    #3;
    rstn = 1'b1;
    step();
    checkState("post rst idle", 4'h0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    checkState("cleared t0", 4'h0, 3'd0, 1'b1, 1'b0);
    step();
    step();
    checkState("cleared t1", 4'h0, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd3);

    // len == 0: single pass ends on the first tick; loop keeps reloading table[0].
    writeTable(3'd0, 4'h5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    checkState("len0 s0", 4'h5, 3'd0, 1'b1, 1'b0);
    step();
    checkState("len0 s1", 4'h5, 3'd0, 1'b1, 1'b0);
    step();
    checkState("len0 done", 4'h5, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    for (int k = 0; k < 4; k++) begin
      step();
    end
    checkState("len0 loop s4", 4'h5, 3'd0, 1'b1, 1'b0);
    writeTable(3'd0, 4'h6);
    checkState("len0 loop s5", 4'h5, 3'd0, 1'b1, 1'b0);
    step();
    checkState("len0 reload", 4'h6, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
